// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - shared types and march element tables for the March C- BIST engine
// Purpose: FSM state type, element count, and the per-element description
//          (address direction, ops per address, read-expect and write bits).
// Ports:   none (package).
package mbist_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   localparam int unsigned NUM_ELEM = 6;
   localparam int unsigned ELEM_W   = 3;
   localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(NUM_ELEM - 1);

   // dn      : addresses descend DEPTH-1..0
   // two_op  : read then write at each address
   // rd_only : single-op element is a read (otherwise a write)
   // exp_bit : background expected on reads
   // wr_bit  : background written
   typedef struct packed {
      logic dn;
      logic two_op;
      logic rd_only;
      logic exp_bit;
      logic wr_bit;
   } elem_cfg_t;

   // March C-: up(w0); up(r0,w1); up(r1,w0); dn(r0,w1); dn(r1,w0); up(r0)
   function automatic elem_cfg_t elem_cfg(input logic [ELEM_W-1:0] elem);
      elem_cfg_t c;
      c = '0;
      case (elem)
         3'd0: c = '{dn: 1'b0, two_op: 1'b0, rd_only: 1'b0, exp_bit: 1'b0, wr_bit: 1'b0};
         3'd1: c = '{dn: 1'b0, two_op: 1'b1, rd_only: 1'b0, exp_bit: 1'b0, wr_bit: 1'b1};
         3'd2: c = '{dn: 1'b0, two_op: 1'b1, rd_only: 1'b0, exp_bit: 1'b1, wr_bit: 1'b0};
         3'd3: c = '{dn: 1'b1, two_op: 1'b1, rd_only: 1'b0, exp_bit: 1'b0, wr_bit: 1'b1};
         3'd4: c = '{dn: 1'b1, two_op: 1'b1, rd_only: 1'b0, exp_bit: 1'b1, wr_bit: 1'b0};
         3'd5: c = '{dn: 1'b0, two_op: 1'b0, rd_only: 1'b1, exp_bit: 1'b0, wr_bit: 1'b0};
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic elem_is_dn(input logic [ELEM_W-1:0] elem);
      elem_cfg_t c;
      c = elem_cfg(elem);
      return c.dn;
   endfunction

endpackage

// File: rtl/mbist_cmp.sv
// rtl/mbist_cmp.sv - registered read-compare stage producing fault events and status
// Purpose: captures (addr, elem, expected) of a read issued in cycle N, compares
//          mem read data in N+1, presents a fault pulse in N+2; keeps sticky fail
//          and a saturating mismatch counter.
// Ports:   clk, rst (async high); clr_i clears fail/count; rd_i/rd_addr_i/rd_elem_i/
//          rd_exp_i describe the read issued this cycle; rdata_i memory read data;
//          flt_valid_o/flt_addr_o/flt_elem_o fault event; flt_count_o, fail_o status.
module mbist_cmp
   import mbist_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              rd_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [ELEM_W-1:0] rd_elem_i,
   input  logic              rd_exp_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic              flt_valid_o,
   output logic [ADDR_W-1:0] flt_addr_o,
   output logic [ELEM_W-1:0] flt_elem_o,
   output logic [CNT_W-1:0]  flt_count_o,
   output logic              fail_o
);

   logic              pend_q;
   logic [ADDR_W-1:0] pend_addr_q;
   logic [ELEM_W-1:0] pend_elem_q;
   logic              pend_exp_q;
   logic              flt_valid_q;
   logic [ADDR_W-1:0] flt_addr_q;
   logic [ELEM_W-1:0] flt_elem_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              fail_q, fail_d;
   logic              mis;

   assign mis = pend_q && (rdata_i != {DATA_W{pend_exp_q}});

   // A start accept never coincides with a pending compare, so clear wins outright.
   always_comb begin
      cnt_d  = cnt_q;
      fail_d = fail_q;
      if (clr_i) begin
         cnt_d  = '0;
         fail_d = 1'b0;
      end else if (mis) begin
         fail_d = 1'b1;
         if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         pend_elem_q <= '0;
         pend_exp_q  <= 1'b0;
         flt_valid_q <= 1'b0;
         flt_addr_q  <= '0;
         flt_elem_q  <= '0;
         cnt_q       <= '0;
         fail_q      <= 1'b0;
      end else begin
         pend_q      <= rd_i;
         if (rd_i) begin
            pend_addr_q <= rd_addr_i;
            pend_elem_q <= rd_elem_i;
            pend_exp_q  <= rd_exp_i;
         end
         flt_valid_q <= mis;
         if (mis) begin
            flt_addr_q <= pend_addr_q;
            flt_elem_q <= pend_elem_q;
         end
         cnt_q  <= cnt_d;
         fail_q <= fail_d;
      end
   end

   assign flt_valid_o = flt_valid_q;
   assign flt_addr_o  = flt_addr_q;
   assign flt_elem_o  = flt_elem_q;
   assign flt_count_o = cnt_q;
   assign fail_o      = fail_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- BIST engine for one single-port SRAM
// Purpose: runs the fixed six-element March C- sequence, one memory op per cycle,
//          reports done/fail and streams per-mismatch fault events.
// Ports:   clk, rst (async high), start (edge-detected run request);
//          mem_addr/mem_we/mem_wdata SRAM command, mem_rdata SRAM read data (1-cycle latency);
//          busy, done, fail status; flt_valid/flt_addr/flt_elem fault event; flt_count.
module mbist_march_ctrl
   import mbist_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic              flt_valid,
   output logic [ADDR_W-1:0] flt_addr,
   output logic [2:0]        flt_elem,
   output logic [CNT_W-1:0]  flt_count
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

   state_e            state_q, state_d;
   logic              start_q;
   logic [ELEM_W-1:0] elem_q, elem_d;
   logic              op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   elem_cfg_t         cfg;
   logic              accept, in_run, is_rd, step, last_addr, nxt_dn;

   assign accept    = start && !start_q && (state_q == IDLE || state_q == DONE);
   assign cfg       = elem_cfg(elem_q);
   assign nxt_dn    = elem_is_dn(elem_q + 3'd1);
   assign in_run    = (state_q == RUN);
   assign is_rd     = cfg.two_op ? !op_q : cfg.rd_only;
   // Advance the address after the write of a two-op element, or every cycle otherwise.
   assign step      = !cfg.two_op || op_q;
   assign last_addr = cfg.dn ? (addr_q == '0) : (addr_q == ADDR_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         elem_q  <= '0;
         op_q    <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start;
         elem_q  <= elem_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      elem_d    = elem_q;
      op_d      = op_q;
      addr_d    = addr_q;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      busy      = (state_q == RUN) || (state_q == DRAIN);
      done      = (state_q == DONE);
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               state_d = RUN;
               elem_d  = '0;
               op_d    = 1'b0;
               addr_d  = '0;
            end
         end
         RUN: begin
            mem_addr  = addr_q;
            mem_we    = !is_rd;
            mem_wdata = is_rd ? '0 : {DATA_W{cfg.wr_bit}};
            if (!step) begin
               op_d = 1'b1;
            end else begin
               op_d = 1'b0;
               if (!last_addr) begin
                  addr_d = cfg.dn ? addr_q - 1'b1 : addr_q + 1'b1;
               end else if (elem_q == LAST_ELEM) begin
                  state_d = DRAIN;
               end else begin
                  // Turn straight onto the next element's first address.
                  elem_d = elem_q + 3'd1;
                  addr_d = nxt_dn ? ADDR_MAX : '0;
               end
            end
         end
         DRAIN: state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   mbist_cmp #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_cmp (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (accept),
      .rd_i        (in_run && is_rd),
      .rd_addr_i   (addr_q),
      .rd_elem_i   (elem_q),
      .rd_exp_i    (cfg.exp_bit),
      .rdata_i     (mem_rdata),
      .flt_valid_o (flt_valid),
      .flt_addr_o  (flt_addr),
      .flt_elem_o  (flt_elem),
      .flt_count_o (flt_count),
      .fail_o      (fail)
   );

endmodule
